peak_amplitude_detector: RTL and testbench
==========================================

# peak_amplitude_detector

Measures the peak-to-peak amplitude of a sample stream over a programmable window of valid samples, emitting max, min and amplitude with a one-cycle result strobe. It sits directly downstream of `cascade_low_pass_filter`, consuming its sample/valid output. This turns filter frequency-response sweeps into per-window amplitude numbers in hardware, and gives the locking loop a signal-level monitor.

## Interface
- `word_width`, 16: sample width. Samples are two's-complement signed.
- `count_width`, 32: width of the window length and sample counter.
- `clk` in 1: 250 MHz system clock.
- `rst` in 1: asynchronous, active-low reset.
- `enable` in 1: measurement enable. Low abandons any partial window.
- `window_len` in `count_width`: number of valid samples per window. 0 means no measurement.
- `sample_in` in `word_width`: signed sample from the filter output bus.
- `sample_valid` in 1: sample qualifier.
- `max_out` out `word_width`: signed maximum of the last completed window.
- `min_out` out `word_width`: signed minimum of the last completed window.
- `amp_out` out `word_width+1`: unsigned `max_out - min_out`.
- `result_valid` out 1: one-cycle pulse when the outputs update.
- `busy` out 1: high while a window is in progress.

## Operation
- States: IDLE, ACCUM.
- **IDLE**
  - Go to ACCUM when `enable`=1 and `window_len`≠0.
  - `window_len` is latched on that transition.
  - The sample counter is cleared and the first-sample flag is set.
- **ACCUM**, on each cycle with `sample_valid`=1:
  - If the first-sample flag is set, seed the running max and min with `sample_in` and clear the flag.
  - Otherwise, update the running max and min with a signed compare.
  - Increment the counter.
- **End of window:** the counter reaches the latched length on the current valid sample.
  - The final max/min, including that sample, are registered to the outputs.
  - `result_valid` pulses.
  - The counter is cleared and the first-sample flag is set.
  - `window_len` is re-latched.
  - The block stays in ACCUM if `enable`=1 and the new `window_len`≠0, otherwise it goes to IDLE.
- **Amplitude arithmetic:** sign-extend both operands to `word_width+1`, then subtract. The result is always ≥0 and never wraps. Full scale (0x7FFF−0x8000) gives 0x0FFFF.
- `window_len` changes in mid-window are ignored until the next window starts.
- `enable` deasserted in ACCUM:
  - Return to IDLE at the next edge.
  - The partial window is discarded and no pulse is produced.
  - Outputs hold their last result.
- `window_len`=1: every valid sample produces a result with max=min and amp 0.
- `sample_valid` while in IDLE is ignored.

## Timing
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - Counter is 0 and the first-sample flag is set.
- Latency: `result_valid` and the new `max_out`/`min_out`/`amp_out` appear on the edge after the clock that accepts the last sample of the window, i.e. 1 cycle later.
- `max_out`, `min_out` and `amp_out` are registered and stay stable between pulses.
- Throughput:
  - No dead cycles between windows.
  - A valid sample in the cycle immediately after the last sample of a window belongs to the next window.
  - Continuous `sample_valid` yields exactly one pulse every `window_len` cycles.
- The first window starts accumulating in the cycle after the IDLE→ACCUM transition. Samples presented during the transition cycle are not counted.
- Mid-operation reset (`rst` low): all outputs clear immediately, asynchronously, and no pulse occurs until a full new window completes.
- Back-to-back pulses occur only when `window_len`=1 with continuous valid.

## Structure
- A shared package (`opo_package`) holds:
  - the state typedef (IDLE, ACCUM);
  - the `word_width` default;
  - the signed-compare helper function used for max/min update.
- No sub-module is needed: a single module with one state register, a counter, and running max/min registers.
- Instantiated per filter output in the frequency-response bench and once in the locking datapath.

## Test plan
- **Constant input:** `sample_in`=0x1000, `window_len`=4, continuous valid → max=min=0x1000 and `amp_out`=0. The pulse occurs 1 cycle after the 4th sample and repeats every 4 cycles.
- **Signed ramp:** −3..+4, `window_len`=8 → `max_out`=0x0004, `min_out`=0xFFFD, `amp_out`=7.
- **Full scale:** alternating 0x7FFF/0x8000, `window_len`=2 → `amp_out`=0x0FFFF with no wrap.
- **Back-to-back windows:** `window_len`=3, samples 1,5,2,9,0,4 with continuous valid → two pulses 3 cycles apart with amp 4 then 9. No sample is lost or double-counted.
- **Sparse valid:** `window_len`=4, `sample_valid` every 3rd cycle → the pulse comes 1 cycle after the 4th valid sample. Non-valid cycles must not affect max/min.
- **Aborts:**
  - `enable` dropped after 2 of 4 samples → no pulse and outputs unchanged.
  - `rst` low mid-window → all outputs 0 immediately, and the next pulse comes only after a full fresh window.
  - `window_len`=0 with `enable`=1 → no pulses and `busy`=0.

Source files
------------

// File: rtl/peak_amplitude_detector_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | opo_package : shared types and helpers for peak_amplitude_detector          |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
package opo_package;

  localparam int c_word_width  = 16;
  localparam int c_count_width = 32;
  // Operands are sign-extended to this width before comparison.
  localparam int c_cmp_width   = 64;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  function automatic logic signed_gt(
    input logic signed [c_cmp_width-1:0] a,
    input logic signed [c_cmp_width-1:0] b
  );
    return a > b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/peak_amplitude_detector_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | peak_amplitude_detector_if : sample stream in, window result out            |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
interface peak_amplitude_detector_if
  import opo_package::*;
#(
  parameter int word_width = c_word_width
);

  logic [word_width-1:0] sample_in;
  logic                  sample_valid;
  logic [word_width-1:0] max_out;
  logic [word_width-1:0] min_out;
  logic [word_width:0]   amp_out;
  logic                  result_valid;

  modport master (
    output sample_in,
    output sample_valid,
    input  max_out,
    input  min_out,
    input  amp_out,
    input  result_valid
  );

  modport slave (
    input  sample_in,
    input  sample_valid,
    output max_out,
    output min_out,
    output amp_out,
    output result_valid
  );

endinterface
`default_nettype wire

// File: rtl/peak_amplitude_detector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | peak_amplitude_detector : per-window signed max/min and peak-to-peak amp    |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module peak_amplitude_detector
  import opo_package::*;
#(
  parameter int word_width  = c_word_width,
  parameter int count_width = c_count_width
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  input  wire logic                   enable,
  input  wire logic [count_width-1:0] window_len,
  output logic                        busy,
  peak_amplitude_detector_if.slave    bus
);

  localparam logic [count_width-1:0] c_count_one = {{(count_width-1){1'b0}}, 1'b1};

  state_t                 r_state;
  logic [count_width-1:0] r_len;
  logic [count_width-1:0] r_count;
  logic                   r_first;
  logic [word_width-1:0]  r_run_max;
  logic [word_width-1:0]  r_run_min;
  logic [word_width-1:0]  r_max_out;
  logic [word_width-1:0]  r_min_out;
  logic [word_width:0]    r_amp_out;
  logic                   r_result_valid;

  logic [c_cmp_width-1:0] w_sample_ext;
  logic [c_cmp_width-1:0] w_run_max_ext;
  logic [c_cmp_width-1:0] w_run_min_ext;
  logic                   w_take_max;
  logic                   w_take_min;
  logic [word_width-1:0]  w_next_max;
  logic [word_width-1:0]  w_next_min;
  logic [word_width:0]    w_amp;
  logic [count_width-1:0] w_count_next;
  logic                   w_last;
  logic                   w_len_nonzero;

  assign w_sample_ext  = {{(c_cmp_width-word_width){bus.sample_in[word_width-1]}}, bus.sample_in};
  assign w_run_max_ext = {{(c_cmp_width-word_width){r_run_max[word_width-1]}}, r_run_max};
  assign w_run_min_ext = {{(c_cmp_width-word_width){r_run_min[word_width-1]}}, r_run_min};

  // The first sample of a window seeds both extremes regardless of history.
  assign w_take_max = r_first || signed_gt(w_sample_ext, w_run_max_ext);
  assign w_take_min = r_first || signed_gt(w_run_min_ext, w_sample_ext);
  assign w_next_max = w_take_max ? bus.sample_in : r_run_max;
  assign w_next_min = w_take_min ? bus.sample_in : r_run_min;

  // One extra bit keeps max - min non-negative even at full scale.
  assign w_amp = {w_next_max[word_width-1], w_next_max}
               - {w_next_min[word_width-1], w_next_min};

  assign w_count_next  = r_count + c_count_one;
  assign w_last        = (w_count_next == r_len);
  assign w_len_nonzero = |window_len;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= IDLE;
      r_len          <= '0;
      r_count        <= '0;
      r_first        <= 1'b1;
      r_run_max      <= '0;
      r_run_min      <= '0;
      r_max_out      <= '0;
      r_min_out      <= '0;
      r_amp_out      <= '0;
      r_result_valid <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (enable && w_len_nonzero) begin
            r_state <= ACCUM;
            r_len   <= window_len;
            r_count <= '0;
            r_first <= 1'b1;
          end
        end
        ACCUM: begin
          if (!enable) begin
            // Partial window is dropped; published results are left untouched.
            r_state <= IDLE;
            r_count <= '0;
            r_first <= 1'b1;
          end else if (bus.sample_valid) begin
            if (w_last) begin
              r_max_out      <= w_next_max;
              r_min_out      <= w_next_min;
              r_amp_out      <= w_amp;
              r_result_valid <= 1'b1;
              r_count        <= '0;
              r_first        <= 1'b1;
              r_len          <= window_len;
              if (!w_len_nonzero) begin
                r_state <= IDLE;
              end
            end else begin
              r_run_max <= w_next_max;
              r_run_min <= w_next_min;
              r_count   <= w_count_next;
              r_first   <= 1'b0;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy             = (r_state == ACCUM);
  assign bus.max_out      = r_max_out;
  assign bus.min_out      = r_min_out;
  assign bus.amp_out      = r_amp_out;
  assign bus.result_valid = r_result_valid;

endmodule
`default_nettype wire

// File: tb/tb_peak_amplitude_detector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_peak_amplitude_detector : scoreboard bench with a window-level model     |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module tb_peak_amplitude_detector;

  localparam int c_ww = 16;
  localparam int c_cw = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic [c_cw-1:0]   window_len;
  logic              busy;

  peak_amplitude_detector_if #(.word_width(c_ww)) bus ();

  peak_amplitude_detector #(
    .word_width  (c_ww),
    .count_width (c_cw)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .window_len (window_len),
    .busy       (busy),
    .bus        (bus)
  );

  always #2 clk = ~clk;

  typedef struct {
    int     mx;
    int     mn;
    int     amp;
    longint due;
  } exp_t;

  exp_t   sb[$];
  int     n_vec = 0;
  int     n_err = 0;
  longint cyc   = 0;

  // Reference model: a window is just the list of accepted samples.
  bit     m_in_win = 1'b0;
  int     m_len    = 0;
  int     m_win[$];
  bit     exp_busy = 1'b0;
  int     last_mx  = 0;
  int     last_mn  = 0;
  int     last_amp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input longint act, input longint req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic void model_step(input bit en, input int wl, input int s, input bit v);
    int mx;
    int mn;
    if (!m_in_win) begin
      if (en && wl != 0) begin
        m_in_win = 1'b1;
        m_len    = wl;
        m_win.delete();
      end
    end else if (!en) begin
      m_in_win = 1'b0;
      m_win.delete();
    end else if (v) begin
      m_win.push_back(s);
      if (m_win.size() == m_len) begin
        mx = m_win[0];
        mn = m_win[0];
        foreach (m_win[i]) begin
          if (m_win[i] > mx) mx = m_win[i];
          if (m_win[i] < mn) mn = m_win[i];
        end
        sb.push_back('{mx: mx, mn: mn, amp: mx - mn, due: cyc + 1});
        m_win.delete();
        m_len = wl;
        if (wl == 0) m_in_win = 1'b0;
      end
    end
    exp_busy = m_in_win;
  endfunction

  task automatic step(input bit en, input int wl, input logic [c_ww-1:0] s, input bit v);
    @(negedge clk);
    check("busy", busy, exp_busy);
    enable           = en;
    window_len       = wl;
    bus.sample_in    = s;
    bus.sample_valid = v;
    model_step(en, wl, int'($signed(s)), v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst              = 1'b0;
    enable           = 1'b0;
    bus.sample_valid = 1'b0;
    #1;
    check("rst_max_out", bus.max_out, 0);
    check("rst_min_out", bus.min_out, 0);
    check("rst_amp_out", bus.amp_out, 0);
    check("rst_result_valid", bus.result_valid, 0);
    check("rst_busy", busy, 0);
    m_in_win = 1'b0;
    m_win.delete();
    sb.delete();
    exp_busy = 1'b0;
    last_mx  = 0;
    last_mn  = 0;
    last_amp = 0;
    @(negedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Monitor: pulses are matched against the scoreboard; between pulses outputs must hold.
  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [15:0] lmx;
    logic [15:0] lmn;
    logic [16:0] lamp;
    if (rst) begin
      if (bus.result_valid) begin
        if (sb.size() == 0) begin
          check("spurious_pulse", 1, 0);
        end else begin
          e = sb.pop_front();
          check("pulse_cycle", cyc, e.due);
          check("max_out", longint'($signed(bus.max_out)), e.mx);
          check("min_out", longint'($signed(bus.min_out)), e.mn);
          check("amp_out", bus.amp_out, e.amp);
          last_mx  = e.mx;
          last_mn  = e.mn;
          last_amp = e.amp;
        end
      end else begin
        lmx  = last_mx[15:0];
        lmn  = last_mn[15:0];
        lamp = last_amp[16:0];
        check("hold_outputs", {bus.max_out, bus.min_out, bus.amp_out}, {lmx, lmn, lamp});
      end
    end
  end

  initial begin
    logic [c_ww-1:0] s;
    int              wl;
    bit              en;
    bit              v;

    rst              = 1'b0;
    enable           = 1'b0;
    window_len       = '0;
    bus.sample_in    = '0;
    bus.sample_valid = 1'b0;
    do_reset();

    // Constant input; the transition-cycle sample differs and must not count.
    step(1'b0, 4, 16'h0000, 1'b0);
    step(1'b1, 4, 16'h7000, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b1, 4, 16'h1000, 1'b1);
    step(1'b0, 4, 16'h0000, 1'b0);

    // Signed ramp -3..+4 over a window of 8.
    step(1'b1, 8, 16'h0000, 1'b0);
    for (int i = -3; i <= 4; i++) begin
      s = 16'(i);
      step(1'b1, 8, s, 1'b1);
    end
    step(1'b0, 8, 16'h0000, 1'b0);

    // Full scale alternating extremes.
    step(1'b1, 2, 16'h0000, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 2, (i % 2 == 0) ? 16'h7FFF : 16'h8000, 1'b1);
    step(1'b0, 2, 16'h0000, 1'b0);

    // Back-to-back windows of 3.
    step(1'b1, 3, 16'h0000, 1'b0);
    step(1'b1, 3, 16'd1, 1'b1);
    step(1'b1, 3, 16'd5, 1'b1);
    step(1'b1, 3, 16'd2, 1'b1);
    step(1'b1, 3, 16'd9, 1'b1);
    step(1'b1, 3, 16'd0, 1'b1);
    step(1'b1, 3, 16'd4, 1'b1);
    step(1'b0, 3, 16'h0000, 1'b0);

    // Sparse valid: junk on non-valid cycles must be ignored.
    step(1'b1, 4, 16'h0000, 1'b0);
    for (int i = 0; i < 12; i++) begin
      if (i % 3 == 2) step(1'b1, 4, 16'($urandom_range(0, 200)), 1'b1);
      else            step(1'b1, 4, (i % 2 == 0) ? 16'h7FFF : 16'h8000, 1'b0);
    end
    step(1'b0, 4, 16'h0000, 1'b0);

    // Window of one: every valid sample is its own result.
    step(1'b1, 1, 16'h0000, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1, 16'($urandom), 1'b1);
    step(1'b0, 1, 16'h0000, 1'b0);

    // Enable dropped after 2 of 4 samples.
    step(1'b1, 4, 16'h0000, 1'b0);
    step(1'b1, 4, 16'h0100, 1'b1);
    step(1'b1, 4, 16'hFF00, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 4, 16'h1234, 1'b1);

    // Reset mid-window, then a full fresh window.
    step(1'b1, 4, 16'h0000, 1'b0);
    step(1'b1, 4, 16'h0222, 1'b1);
    step(1'b1, 4, 16'h0333, 1'b1);
    do_reset();
    step(1'b1, 4, 16'h0000, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 4, 16'($urandom), 1'b1);
    step(1'b0, 4, 16'h0000, 1'b0);

    // Zero window length never starts.
    for (int i = 0; i < 8; i++) step(1'b1, 0, 16'($urandom), 1'b1);
    step(1'b0, 0, 16'h0000, 1'b0);

    // Random traffic, including mid-window window_len changes.
    wl = 3;
    for (int i = 0; i < 500; i++) begin
      en = ($urandom_range(0, 24) != 0);
      if ($urandom_range(0, 19) == 0) wl = $urandom_range(0, 6);
      v  = ($urandom_range(0, 3) != 0);
      step(en, wl, 16'($urandom), v);
    end

    for (int i = 0; i < 4; i++) step(1'b0, 0, 16'h0000, 1'b0);
    check("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
